twofour_decoder_pipe: RTL and testbench
=======================================

// Module: twofour_decoder_pipe
// PURPOSE
//   Streaming 2-to-4 decoder; the inverse of the fourtwo encoder (e1,e0 -> one-hot a..d).
//   Accepts 2-bit codes over a valid/ready handshake, decodes them to one-hot and buffers
//   the results in a 2-entry skid stage. Drives the downstream lab display/LED path.
//   Also keeps a running count of delivered symbols.
// PARAMETERS
//   CNT_W   8   width of sym_count and of each histogram counter; counters wrap at 2**CNT_W
// PORTS
//   clk         in   1        single clock, rising edge
//   rst_n       in   1        asynchronous, active-low reset
//   in_valid    in   1        upstream code valid
//   in_code     in   2        {e1,e0} code to decode
//   in_en       in   1        decoder enable; 0 => symbol decodes to 4'b0000
//   in_ready    out  1        block can accept a symbol this cycle
//   out_valid   out  1        out_onehot holds a decoded symbol
//   out_onehot  out  4        {d,c,b,a} one-hot result
//   out_ready   in   1        downstream accepts symbol
//   sym_count   out  CNT_W    number of symbols delivered (output handshakes)
//   hist_cnt    out  4*CNT_W  per-code delivered counts, [k*CNT_W +: CNT_W] = code k (macro only)
// BEHAVIOUR
//   - Decode: code0->0001, code1->0010, code2->0100, code3->1000; in_en=0 -> 0000 for any code.
//   - Push when in_valid && in_ready; pop when out_valid && out_ready.
//   - Buffer: 2 entries, FIFO order, occupancy 0..2. in_ready = (occupancy < 2), registered.
//   - Latency: symbol pushed at edge N appears on out_onehot with out_valid=1 after edge N
//     when the buffer was empty (1 cycle); otherwise after all older entries pop.
//   - Full-rate: with out_ready held 1, one symbol per cycle sustained, no bubbles.
//   - Push+pop same edge: occupancy unchanged; head advances, new entry appended.
//   - Full (2): in_ready=0; in_valid ignored; stalled inputs must be held by upstream.
//   - Empty: out_valid=0; out_onehot driven 4'b0000 (not X).
//   - Stability: while out_valid && !out_ready, out_onehot holds its value.
//   - sym_count increments by 1 on every pop; wraps 2**CNT_W-1 -> 0.
//   - Reset (any time, incl. mid-stream): buffer flushed, occupancy 0, out_valid=0,
//     out_onehot=0, in_ready=1, sym_count=0, hist_cnt=0. No partial symbol survives.
//   - First edge after rst_n deasserts may push.
// CONFIGURATION
//   TWOFOUR_HIST_EN defined: hist_cnt port present; on each pop of a non-zero one-hot,
//     counter for the set bit increments (wraps like sym_count); in_en=0 symbols are
//     counted in sym_count only.
//   TWOFOUR_HIST_EN undefined: hist_cnt port and counters absent; all else identical.
// STRUCTURE
//   - Package twofour_pkg: typedef code_t (logic [1:0]), typedef onehot_t (logic [3:0]),
//     localparam onehot_t ONEHOT_NONE = 4'b0000, function decode(code_t, logic en).
//   - Sub-module twofour_skid: 2-entry valid/ready buffer, width-parameterised, holds
//     occupancy/in_ready logic. Top does decode, counters, histogram.
// TESTING
//   1 Reset: rst_n=0 -> out_valid=0, out_onehot=0, in_ready=1, sym_count=0.
//   2 Decode sweep, out_ready=1, in_en=1, codes 0,1,2,3 back-to-back -> outputs
//     0001,0010,0100,1000 on consecutive cycles, sym_count=4.
//   3 Backpressure: out_ready=0, push codes 2,3 -> in_ready=0 after 2nd push, out_onehot
//     holds 0100; 3rd in_valid ignored; release out_ready -> 0100 then 1000, order kept.
//   4 Enable: in_en=0, code 3 -> out_onehot=0000, out_valid=1, sym_count+1,
//     hist_cnt unchanged (macro on).
//   5 Async reset mid-stream: buffer holding 2 entries, pulse rst_n low between edges ->
//     outputs clear immediately, no stale symbol after release.
//   6 Wrap: CNT_W=2, deliver 5 symbols of code 1 -> sym_count=1, hist_cnt[1]=1 (macro on).

Source files
------------

// File: rtl/twofour_pkg.sv
// ---------------------------------------------------------------------------
// twofour_pkg
//   Shared types and helpers for the streaming 2-to-4 decoder.
//   - code_t      : 2-bit {e1,e0} input code
//   - onehot_t    : 4-bit {d,c,b,a} one-hot result
//   - ONEHOT_NONE : all-zero symbol, used for disabled decodes and idle output
//   - occ_t       : occupancy state of the 2-entry skid buffer
//   - decode()    : code/enable -> one-hot
// ---------------------------------------------------------------------------
package twofour_pkg;

    typedef logic [1:0] code_t;
    typedef logic [3:0] onehot_t;

    localparam onehot_t ONEHOT_NONE = 4'b0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic onehot_t decode(input code_t code, input logic en);
        onehot_t result;
        if (en) begin
            result = onehot_t'(4'b0001 << code);
        end else begin
            result = ONEHOT_NONE;
        end
        return result;
    endfunction

endpackage

// File: rtl/twofour_decoder_pipe_skid.sv
// ---------------------------------------------------------------------------
// twofour_skid
//   Two-entry FIFO-ordered valid/ready buffer.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_data    upstream symbol, accepted when in_ready
//     in_ready            registered: high while fewer than 2 entries are held
//     out_valid/out_data  head of buffer; out_data is zero while empty
//     out_ready           downstream accepts head this cycle
//   Occupancy is a small two-process state machine; the data slots carry no
//   reset because the output is gated by out_valid.
// ---------------------------------------------------------------------------
module twofour_skid
    import twofour_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    occ_t              occ;
    occ_t              occ_next;
    logic              push;
    logic              pop;
    logic              load_head;
    logic              load_tail;
    logic              head_from_tail;
    logic [DATA_W-1:0] head_p1;
    logic [DATA_W-1:0] tail_p1;

    assign push      = in_valid && in_ready;
    assign out_valid = (occ != OCC_EMPTY);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head_p1 : '0;

    always_comb begin
        occ_next       = occ;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    load_head = 1'b1;
                    occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b11: load_head = 1'b1;      // head leaves, new symbol takes its place
                    2'b10: begin
                        load_tail = 1'b1;
                        occ_next  = OCC_FULL;
                    end
                    2'b01: occ_next = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen
                if (pop) begin
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                    occ_next       = OCC_ONE;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    // Stage boundary: control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= OCC_EMPTY;
            in_ready <= 1'b1;
        end else begin
            occ      <= occ_next;
            in_ready <= (occ_next != OCC_FULL);
        end
    end

    // Stage boundary: data slots
    always_ff @(posedge clk) begin
        if (load_head) begin
            head_p1 <= head_from_tail ? tail_p1 : in_data;
        end
        if (load_tail) begin
            tail_p1 <= in_data;
        end
    end

endmodule

// File: rtl/twofour_decoder_pipe.sv
// ---------------------------------------------------------------------------
// twofour_decoder_pipe
//   Streaming 2-to-4 decoder: accepts {e1,e0} codes over valid/ready, decodes
//   them to one-hot {d,c,b,a} and buffers results in a 2-entry skid stage.
//   Counts delivered symbols; optionally keeps a per-code delivery histogram.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     in_valid, in_code, in_en    upstream symbol; in_en=0 decodes to 0000
//     in_ready                    block can accept a symbol this cycle
//     out_valid, out_onehot       decoded head symbol (0000 while empty)
//     out_ready                   downstream accepts symbol
//     sym_count                   delivered symbol count, wraps at 2**CNT_W
//     hist_cnt                    per-code counts, [k*CNT_W +: CNT_W] = code k
//   Configuration macro: TWOFOUR_HIST_EN adds the hist_cnt port and counters.
// ---------------------------------------------------------------------------
module twofour_decoder_pipe
    import twofour_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  code_t            in_code,
    input  logic             in_en,
    output logic             in_ready,
    output logic             out_valid,
    output onehot_t          out_onehot,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sym_count
`ifdef TWOFOUR_HIST_EN
    ,
    output logic [4*CNT_W-1:0] hist_cnt
`endif
);

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
        return v + CNT_W'(1);
    endfunction

    onehot_t decoded_p0;
    logic    pop;

    assign decoded_p0 = decode(in_code, in_en);
    assign pop        = out_valid && out_ready;

    twofour_skid #(
        .DATA_W (4)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (decoded_p0),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_onehot),
        .out_ready (out_ready)
    );

    // Stage boundary: delivered-symbol counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count <= '0;
        end else if (pop) begin
            sym_count <= wrap_inc(sym_count);
        end
    end

`ifdef TWOFOUR_HIST_EN
    logic [CNT_W-1:0] hist_p1 [4];

    // Stage boundary: per-code histogram; an all-zero symbol matches no bin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hist_p1[k] <= '0;
            end
        end else if (pop) begin
            for (int k = 0; k < 4; k++) begin
                if (out_onehot[k]) begin
                    hist_p1[k] <= wrap_inc(hist_p1[k]);
                end
            end
        end
    end

    always_comb begin
        hist_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            hist_cnt[k*CNT_W +: CNT_W] = hist_p1[k];
        end
    end
`endif

endmodule

// File: tb/tb_twofour_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_twofour_decoder_pipe
//   Directed-vector bench for twofour_decoder_pipe. A second instance with
//   CNT_W=2 exercises counter wrap. Build with TWOFOUR_HIST_EN to include
//   the histogram checks.
// ---------------------------------------------------------------------------
module tb_twofour_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic [1:0] in_code = 2'd0;
    logic       in_en = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_onehot;
    logic       out_ready = 1'b1;
    logic [7:0] sym_count;

    logic       w_in_valid = 1'b0;
    logic [1:0] w_in_code = 2'd1;
    logic       w_in_en = 1'b1;
    logic       w_in_ready;
    logic       w_out_valid;
    logic [3:0] w_out_onehot;
    logic       w_out_ready = 1'b1;
    logic [1:0] w_sym_count;

`ifdef TWOFOUR_HIST_EN
    logic [31:0] hist_cnt;
    logic [7:0]  w_hist_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    twofour_decoder_pipe #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_en      (in_en),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .sym_count  (sym_count)
`ifdef TWOFOUR_HIST_EN
        ,
        .hist_cnt   (hist_cnt)
`endif
    );

    twofour_decoder_pipe #(.CNT_W(2)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w_in_valid),
        .in_code    (w_in_code),
        .in_en      (w_in_en),
        .in_ready   (w_in_ready),
        .out_valid  (w_out_valid),
        .out_onehot (w_out_onehot),
        .out_ready  (w_out_ready),
        .sym_count  (w_sym_count)
`ifdef TWOFOUR_HIST_EN
        ,
        .hist_cnt   (w_hist_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected output after each cycle of a directed sequence
    task automatic check_out(input string tag, input logic v, input logic [3:0] oh,
                             input logic rdy, input logic [7:0] cnt);
        check({tag, ".out_valid"},  32'(out_valid),  32'(v));
        check({tag, ".out_onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
        check({tag, ".sym_count"},  32'(sym_count),  32'(cnt));
    endtask

    initial begin
        // 1: reset state
        step();
        step();
        check_out("reset", 1'b0, 4'b0000, 1'b1, 8'd0);
        rst_n = 1'b1;

        // 2: decode sweep at full rate
        out_ready = 1'b1;
        in_en     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd0; step(); check_out("sweep0", 1'b1, 4'b0001, 1'b1, 8'd0);
        in_code   = 2'd1; step(); check_out("sweep1", 1'b1, 4'b0010, 1'b1, 8'd1);
        in_code   = 2'd2; step(); check_out("sweep2", 1'b1, 4'b0100, 1'b1, 8'd2);
        in_code   = 2'd3; step(); check_out("sweep3", 1'b1, 4'b1000, 1'b1, 8'd3);
        in_valid  = 1'b0; step(); check_out("sweep_end", 1'b0, 4'b0000, 1'b1, 8'd4);

        // 3: backpressure, full buffer, ordering
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd2; step(); check_out("bp_push1", 1'b1, 4'b0100, 1'b1, 8'd4);
        in_code   = 2'd3; step(); check_out("bp_push2", 1'b1, 4'b0100, 1'b0, 8'd4);
        in_code   = 2'd1; step(); check_out("bp_ignored", 1'b1, 4'b0100, 1'b0, 8'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1; step(); check_out("bp_pop1", 1'b1, 4'b1000, 1'b1, 8'd5);
        step();               check_out("bp_pop2", 1'b0, 4'b0000, 1'b1, 8'd6);

        // 4: disabled decode
        in_en    = 1'b0;
        in_code  = 2'd3;
        in_valid = 1'b1; step(); check_out("en0_push", 1'b1, 4'b0000, 1'b1, 8'd6);
        in_valid = 1'b0; step(); check_out("en0_pop", 1'b0, 4'b0000, 1'b1, 8'd7);
`ifdef TWOFOUR_HIST_EN
        // delivered so far: codes 0,1,2,3,2,3 plus one disabled symbol
        check("hist_after_en0", hist_cnt, {8'd2, 8'd2, 8'd1, 8'd1});
`endif
        in_en = 1'b1;

        // 5: asynchronous reset with a full buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd0; step();
        in_code   = 2'd1; step(); check_out("pre_rst_full", 1'b1, 4'b0001, 1'b0, 8'd7);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 1'b0, 4'b0000, 1'b1, 8'd0);
`ifdef TWOFOUR_HIST_EN
        check("hist_async_rst", hist_cnt, 32'd0);
`endif
        #1 rst_n = 1'b1;
        step(); check_out("post_rst_idle", 1'b0, 4'b0000, 1'b1, 8'd0);
        in_valid = 1'b1;
        in_code  = 2'd2; step(); check_out("post_rst_push", 1'b1, 4'b0100, 1'b1, 8'd0);
        in_valid = 1'b0; step(); check_out("post_rst_pop", 1'b0, 4'b0000, 1'b1, 8'd1);

        // 6: counter wrap on the CNT_W=2 instance, five code-1 symbols
        w_in_code  = 2'd1;
        w_in_en    = 1'b1;
        w_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wrap_stream_onehot", 32'(w_out_onehot), 32'(4'b0010));
        end
        w_in_valid = 1'b0;
        step();
        check("wrap_out_valid", 32'(w_out_valid), 32'd0);
        check("wrap_sym_count", 32'(w_sym_count), 32'd1);
`ifdef TWOFOUR_HIST_EN
        check("wrap_hist1", 32'(w_hist_cnt), 32'(8'b00_00_01_00));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
